// File: rtl/audio_mix_sched_if.sv
// Source/mix bundle for the shared-multiplier audio mixer.
// Master drives the sources; slave is the mixer.
interface audio_mix_sched_if #(
    parameter int NUM_PAIRS = 2
);
    localparam int N = 2 * NUM_PAIRS;

    logic               next_sample;
    logic [16*N-1:0]    src_data;
    logic [7*N-1:0]     src_gain;
    logic [N-1:0]       src_en;
    logic               overrun_clr;
    logic signed [15:0] mix_left;
    logic signed [15:0] mix_right;
    logic               mix_valid;
    logic               busy;
    logic               overrun;

    modport master (
        output next_sample, src_data, src_gain, src_en, overrun_clr,
        input  mix_left, mix_right, mix_valid, busy, overrun
    );

    modport slave (
        input  next_sample, src_data, src_gain, src_en, overrun_clr,
        output mix_left, mix_right, mix_valid, busy, overrun
    );
endinterface

// File: rtl/audio_mix_sched.sv
// Time-multiplexed gain + stereo mix over one signed 16x7 multiplier.
// One slot per RUN cycle, then drain, then a saturated registered output.
module audio_mix_sched #(
    parameter int NUM_PAIRS = 2,
    parameter int ACC_W     = 26
) (
    input logic              clk,
    input logic              rst,
    audio_mix_sched_if.slave bus
);
    localparam int N  = 2 * NUM_PAIRS;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    logic [1:0]             state;
    logic [SW-1:0]          slot;
    logic [N-1:0][15:0]     sh_data;
    logic [N-1:0][6:0]      sh_gain;
    logic [N-1:0]           sh_en;
    logic signed [22:0]     prod;
    logic                   prod_vld;
    logic                   prod_odd;
    logic signed [ACC_W-1:0] acc_l;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [15:0]     mix_l;
    logic signed [15:0]     mix_r;
    logic                   valid;
    logic                   ovr;

    logic signed [15:0]     cur_d;
    logic signed [7:0]      cur_g;
    logic signed [23:0]     p_full;
    logic signed [22:0]     prod_next;
    logic signed [ACC_W-1:0] prod_ext;

    function automatic logic signed [15:0] sat16(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W-1:0] s;
        s = a >>> 6;
        if (s > SAT_MAX)
            return 16'sh7fff;
        else if (s < SAT_MIN)
            return 16'sh8000;
        else
            return s[15:0];
    endfunction

    // Gain is zero-extended so 0..127 stays positive in the signed product.
    always_comb begin
        cur_d     = sh_data[slot];
        cur_g     = {1'b0, sh_gain[slot]};
        p_full    = cur_d * cur_g;
        prod_next = sh_en[slot] ? p_full[22:0] : '0;
        prod_ext  = {{(ACC_W-23){prod[22]}}, prod};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            slot     <= '0;
            sh_data  <= '0;
            sh_gain  <= '0;
            sh_en    <= '0;
            prod     <= '0;
            prod_vld <= 1'b0;
            prod_odd <= 1'b0;
            acc_l    <= '0;
            acc_r    <= '0;
            mix_l    <= '0;
            mix_r    <= '0;
            valid    <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            valid    <= 1'b0;
            prod_vld <= 1'b0;

            if (bus.next_sample && state != IDLE)
                ovr <= 1'b1;
            else if (bus.overrun_clr)
                ovr <= 1'b0;

            // Product registered last cycle lands in its channel now.
            if (prod_vld) begin
                if (prod_odd)
                    acc_r <= acc_r + prod_ext;
                else
                    acc_l <= acc_l + prod_ext;
            end

            case (state)
                IDLE: begin
                    if (bus.next_sample) begin
                        sh_data <= bus.src_data;
                        sh_gain <= bus.src_gain;
                        sh_en   <= bus.src_en;
                        acc_l   <= '0;
                        acc_r   <= '0;
                        slot    <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    prod     <= prod_next;
                    prod_odd <= slot[0];
                    prod_vld <= 1'b1;
                    if (slot == SW'(N - 1)) begin
                        slot  <= '0;
                        state <= DRAIN;
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                end
                DONE: begin
                    mix_l <= sat16(acc_l);
                    mix_r <= sat16(acc_r);
                    valid <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mix_left  = mix_l;
    assign bus.mix_right = mix_r;
    assign bus.mix_valid = valid;
    assign bus.busy      = (state != IDLE);
    assign bus.overrun   = ovr;
endmodule

// File: tb/tb_audio_mix_sched.sv
// Self-checking bench for audio_mix_sched: vector table + scoreboard
// plus hand-written snapshot/overrun/reset-abort sequences.
module tb_audio_mix_sched;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    audio_mix_sched_if #(.NUM_PAIRS(2)) bus ();

    audio_mix_sched #(.NUM_PAIRS(2), .ACC_W(26)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic signed [15:0] d [4];
        logic [6:0]         g [4];
        logic [3:0]         en;
        logic signed [15:0] el;
        logic signed [15:0] er;
    } vec_t;

    typedef struct {
        logic signed [15:0] l;
        logic signed [15:0] r;
    } exp_t;

    vec_t vec [6];
    vec_t junk;
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   vcount = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input int d0, input int d1, input int d2, input int d3,
        input int g0, input int g1, input int g2, input int g3,
        input logic [3:0] en, input int el, input int er
    );
        vec_t v;
        v.d[0] = 16'(d0); v.d[1] = 16'(d1);
        v.d[2] = 16'(d2); v.d[3] = 16'(d3);
        v.g[0] = 7'(g0);  v.g[1] = 7'(g1);
        v.g[2] = 7'(g2);  v.g[3] = 7'(g3);
        v.en = en;
        v.el = 16'(el);
        v.er = 16'(er);
        return v;
    endfunction

    task automatic load(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            bus.src_data[16*i +: 16] = v.d[i];
            bus.src_gain[7*i +: 7]   = v.g[i];
        end
        bus.src_en = v.en;
    endtask

    task automatic push(input vec_t v);
        exp_t e;
        e.l = v.el;
        e.r = v.er;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every mix_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.mix_valid) begin
            exp_t e;
            vcount++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got L=%0d R=%0d expected none",
                         bus.mix_left, bus.mix_right);
            end else begin
                e = sb.pop_front();
                check("mix_left", int'(bus.mix_left), int'(e.l));
                check("mix_right", int'(bus.mix_right), int'(e.r));
            end
        end
    end

    task automatic wait_frame(output bit seen, output int bc);
        seen = 1'b0;
        bc   = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (bus.busy) bc++;
            if (bus.mix_valid) seen = 1'b1;
        end
    endtask

    task automatic run_frame(input vec_t v);
        bit seen;
        int bc;
        @(posedge clk); #1;
        load(v);
        bus.next_sample = 1'b1;
        push(v);
        @(posedge clk); #1;
        bus.next_sample = 1'b0;
        load(junk);
        wait_frame(seen, bc);
        check("frame_done", int'(seen), 1);
        check("busy_cycles", bc, 6);
        @(negedge clk);
        check("valid_pulse_width", int'(bus.mix_valid), 0);
    endtask

    initial begin
        bit seen;
        int bc;
        int v0;

        vec[0] = mk(1000, -2000, 0, 0, 64, 64, 0, 0, 4'hf, 1000, -2000);
        vec[1] = mk(30000, -30000, 30000, -30000, 64, 64, 64, 64, 4'hf,
                    32767, -32768);
        vec[2] = mk(-3, 20000, 0, 0, 32, 127, 0, 0, 4'hf, -2, 32767);
        vec[3] = mk(10000, 10000, 10000, 10000, 64, 64, 64, 64, 4'b0101,
                    20000, 0);
        vec[4] = mk(5000, 100, -640, 7, 0, 64, 1, 64, 4'hf, -10, 107);
        vec[5] = mk(-1, 63, 0, 0, 1, 1, 0, 0, 4'hf, -1, 0);
        junk   = mk(12345, 12345, 12345, 12345, 100, 100, 100, 100, 4'hf,
                    0, 0);

        rst             = 1'b1;
        bus.next_sample = 1'b0;
        bus.overrun_clr = 1'b0;
        bus.src_data    = '0;
        bus.src_gain    = '0;
        bus.src_en      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mix_left", int'(bus.mix_left), 0);
        check("rst_mix_right", int'(bus.mix_right), 0);
        check("rst_mix_valid", int'(bus.mix_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_frame(vec[i]);
        check("no_overrun_yet", int'(bus.overrun), 0);

        // Snapshot + overrun: data changes and a re-strobe mid-frame.
        v0 = vcount;
        @(posedge clk); #1;
        load(vec[0]);
        bus.next_sample = 1'b1;
        push(vec[0]);
        @(posedge clk); #1;
        bus.next_sample = 1'b0;
        @(posedge clk); #1;
        load(junk);
        @(posedge clk); #1;
        bus.next_sample = 1'b1;
        @(posedge clk); #1;
        bus.next_sample = 1'b0;
        wait_frame(seen, bc);
        check("snap_frame_done", int'(seen), 1);
        repeat (8) @(negedge clk);
        check("single_valid", vcount - v0, 1);
        check("overrun_set", int'(bus.overrun), 1);

        // Clear coinciding with a busy strobe: set wins.
        @(posedge clk); #1;
        load(vec[1]);
        bus.next_sample = 1'b1;
        push(vec[1]);
        @(posedge clk); #1;
        bus.next_sample = 1'b0;
        @(posedge clk); #1;
        bus.next_sample = 1'b1;
        bus.overrun_clr = 1'b1;
        @(posedge clk); #1;
        bus.next_sample = 1'b0;
        bus.overrun_clr = 1'b0;
        @(negedge clk);
        check("overrun_set_wins", int'(bus.overrun), 1);
        wait_frame(seen, bc);
        check("setwins_frame_done", int'(seen), 1);
        @(posedge clk); #1;
        bus.overrun_clr = 1'b1;
        @(posedge clk); #1;
        bus.overrun_clr = 1'b0;
        @(negedge clk);
        check("overrun_cleared", int'(bus.overrun), 0);

        // Reset lands in the third RUN cycle: frame aborted.
        run_frame(vec[0]);
        v0 = vcount;
        @(posedge clk); #1;
        load(vec[1]);
        bus.next_sample = 1'b1;
        @(posedge clk); #1;
        bus.next_sample = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_valid", vcount - v0, 0);
        check("abort_mix_left", int'(bus.mix_left), 0);
        check("abort_mix_right", int'(bus.mix_right), 0);
        check("abort_busy", int'(bus.busy), 0);
        run_frame(vec[2]);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
